// File: rtl/pu_controller.sv
// Layer sequencer for a 4-input processing unit: streams one weight word per neuron,
// tracks the PU's two-register pipeline and buffers results in a credit-guarded FIFO.
module pu_controller #(
  parameter int AW         = 6,
  parameter int FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] num_neurons,
  input  logic          act_we,
  input  logic [1:0]    act_idx,
  input  logic [4:0]    act_wdata,
  output logic          busy,
  output logic          done,
  output logic          wmem_ren,
  output logic [AW-1:0] wmem_addr,
  input  logic [19:0]   wmem_rdata,
  output logic [4:0]    pu_a1,
  output logic [4:0]    pu_a2,
  output logic [4:0]    pu_a3,
  output logic [4:0]    pu_a4,
  output logic [4:0]    pu_w1,
  output logic [4:0]    pu_w2,
  output logic [4:0]    pu_w3,
  output logic [4:0]    pu_w4,
  input  logic [4:0]    pu_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [4:0]    res_data,
  output logic [AW-1:0] res_idx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(FIFO_DEPTH + 4) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  typedef struct packed {
    logic [4:0]    data;
    logic [AW-1:0] idx;
  } entry_t;

  state_e        state_q, state_d;
  logic [AW-1:0] num_q, num_d;
  logic [AW-1:0] issued_q, issued_d;
  logic          wren_q, wren_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic          done_q, done_d;
  logic          p1_q, p2_q, p3_q;
  logic [AW-1:0] p1_idx_q, p2_idx_q, p3_idx_q;
  logic [4:0]    act_q [4];

  entry_t        mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  entry_t        head;
  logic          push, pop, last_pop;
  logic [OW-1:0] occupancy;

  assign head = mem_q[rd_ptr_q];
  assign push = p3_q;
  assign pop  = (count_q != '0) && res_ready;

  // Credit: every in-flight read will claim a FIFO slot; same-edge pops are not counted.
  assign occupancy = OW'(count_q) + OW'(wren_q) + OW'(p1_q) + OW'(p2_q) + OW'(p3_q);
  assign last_pop  = pop && (state_q == S_DRAIN) && (head.idx == num_q - AW'(1));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    issued_d = issued_q;
    wren_d   = 1'b0;
    waddr_d  = waddr_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_neurons == '0) begin
            done_d = 1'b1;
          end else begin
            num_d    = num_neurons;
            issued_d = AW'(1);
            wren_d   = 1'b1;
            waddr_d  = '0;
            state_d  = (num_neurons == AW'(1)) ? S_DRAIN : S_RUN;
          end
        end
      end
      S_RUN: begin
        if ((issued_q < num_q) && (occupancy < OW'(FIFO_DEPTH))) begin
          wren_d   = 1'b1;
          waddr_d  = issued_q;
          issued_d = issued_q + AW'(1);
          if (issued_q + AW'(1) == num_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (last_pop) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      num_q    <= '0;
      issued_q <= '0;
      wren_q   <= 1'b0;
      waddr_q  <= '0;
      done_q   <= 1'b0;
      p1_q     <= 1'b0;
      p2_q     <= 1'b0;
      p3_q     <= 1'b0;
      p1_idx_q <= '0;
      p2_idx_q <= '0;
      p3_idx_q <= '0;
      act_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      issued_q <= issued_d;
      wren_q   <= wren_d;
      waddr_q  <= waddr_d;
      done_q   <= done_d;
      p1_q     <= wren_q;
      p2_q     <= p1_q;
      p3_q     <= p2_q;
      p1_idx_q <= waddr_q;
      p2_idx_q <= p1_idx_q;
      p3_idx_q <= p2_idx_q;
      if (act_we && (state_q == S_IDLE)) act_q[act_idx] <= act_wdata;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // NOTE: FIFO storage is not reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{data: pu_out, idx: p3_idx_q};
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign wmem_ren  = wren_q;
  assign wmem_addr = waddr_q;

  assign pu_w1 = p1_q ? wmem_rdata[4:0]   : '0;
  assign pu_w2 = p1_q ? wmem_rdata[9:5]   : '0;
  assign pu_w3 = p1_q ? wmem_rdata[14:10] : '0;
  assign pu_w4 = p1_q ? wmem_rdata[19:15] : '0;
  assign pu_a1 = p1_q ? act_q[0] : '0;
  assign pu_a2 = p1_q ? act_q[1] : '0;
  assign pu_a3 = p1_q ? act_q[2] : '0;
  assign pu_a4 = p1_q ? act_q[3] : '0;

  // Head fields read as zero while empty so nothing stale is presented.
  assign res_valid = (count_q != '0);
  assign res_data  = res_valid ? head.data : '0;
  assign res_idx   = res_valid ? head.idx  : '0;

endmodule

// File: tb/tb_pu_controller.sv
// Self-checking bench for pu_controller: weight memory and PU models around the DUT,
// a job-level scoreboard checked every cycle, plus directed literal timing checks.
module tb_pu_controller;

  localparam int AW    = 6;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst, start, act_we, res_ready;
  logic [AW-1:0] num_neurons;
  logic [1:0]    act_idx;
  logic [4:0]    act_wdata;
  logic          busy, done, wmem_ren, res_valid;
  logic [AW-1:0] wmem_addr, res_idx;
  logic [19:0]   wmem_rdata;
  logic [4:0]    pu_a1, pu_a2, pu_a3, pu_a4, pu_w1, pu_w2, pu_w3, pu_w4, pu_out, res_data;

  pu_controller #(.AW(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .num_neurons(num_neurons),
    .act_we(act_we), .act_idx(act_idx), .act_wdata(act_wdata),
    .busy(busy), .done(done), .wmem_ren(wmem_ren), .wmem_addr(wmem_addr),
    .wmem_rdata(wmem_rdata),
    .pu_a1(pu_a1), .pu_a2(pu_a2), .pu_a3(pu_a3), .pu_a4(pu_a4),
    .pu_w1(pu_w1), .pu_w2(pu_w2), .pu_w3(pu_w3), .pu_w4(pu_w4),
    .pu_out(pu_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_idx(res_idx)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Weight word for neuron i: w1 = i mod 32, w2 = 1, w3 = w4 = 0.
  function automatic logic [19:0] word_of(input int i);
    logic [4:0] w1;
    w1 = 5'(i % 32);
    return {5'd0, 5'd0, 5'd1, w1};
  endfunction

  int model_act [4];

  function automatic logic [4:0] exp_res(input int i);
    logic [19:0] w;
    int s;
    w = word_of(i);
    s = model_act[0] * int'(w[4:0])   + model_act[1] * int'(w[9:5]) +
        model_act[2] * int'(w[14:10]) + model_act[3] * int'(w[19:15]);
    return (s > 31) ? 5'd31 : 5'(s);
  endfunction

  // Synchronous weight memory.
  always @(posedge clk) if (wmem_ren) wmem_rdata <= word_of(int'(wmem_addr));

  // PU: multiplier register, adder-tree register, saturating activation.
  logic [9:0]  m1, m2, m3, m4;
  logic [11:0] acc;
  always @(posedge clk) begin
    if (rst) begin
      m1 <= '0; m2 <= '0; m3 <= '0; m4 <= '0; acc <= '0;
    end else begin
      m1 <= pu_a1 * pu_w1; m2 <= pu_a2 * pu_w2;
      m3 <= pu_a3 * pu_w3; m4 <= pu_a4 * pu_w4;
      acc <= m1 + m2 + m3 + m4;
    end
  end
  assign pu_out = (acc > 12'd31) ? 5'd31 : acc[4:0];

  // Job-level scoreboard state.
  bit          mon_en = 0;
  bit          job_active = 0, done_exp = 0, reset_next = 0, rd_valid = 0;
  bit          prev_valid = 0, prev_ready = 0;
  int          job_n = 0, ren_cnt = 0, pop_cnt = 0, exp_idx = 0, done_count = 0, rd_addr = 0;
  logic [AW-1:0] prev_idx;
  logic [4:0]  prev_data;
  logic [4:0]  got_data [64];

  always @(negedge clk) begin
    bit ja_now, popped_last, done_next;
    if (mon_en) begin
      ja_now      = job_active;
      popped_last = 0;
      done_next   = 0;
      if (reset_next) begin
        check("rst_ctl", {busy, done, wmem_ren, wmem_addr, res_valid, res_data, res_idx}, 0);
        check("rst_pu", {pu_a1, pu_a2, pu_a3, pu_a4, pu_w1, pu_w2, pu_w3, pu_w4}, 0);
      end else begin
        check("busy", busy, job_active);
        check("done", done, done_exp);
        if (rd_valid) begin
          check("pu_w", {pu_w4, pu_w3, pu_w2, pu_w1}, word_of(rd_addr));
          check("pu_a", {pu_a4, pu_a3, pu_a2, pu_a1},
                {5'(model_act[3]), 5'(model_act[2]), 5'(model_act[1]), 5'(model_act[0])});
        end else begin
          check("pu_idle", {pu_a1, pu_a2, pu_a3, pu_a4, pu_w1, pu_w2, pu_w3, pu_w4}, 0);
        end
        if (wmem_ren) begin
          check("ren_addr", wmem_addr, ren_cnt);
          ren_cnt++;
          check("ren_bound", ren_cnt <= job_n, 1);
        end
        check("credit", (ren_cnt - pop_cnt) <= DEPTH, 1);
        if (prev_valid && !prev_ready)
          check("hold", {res_valid, res_idx, res_data}, {1'b1, prev_idx, prev_data});
        if (res_valid && res_ready) begin
          check("res_idx", res_idx, exp_idx);
          check("res_data", res_data, exp_res(exp_idx));
          if (exp_idx < 64) got_data[exp_idx] = res_data;
          exp_idx++;
          pop_cnt++;
          if (job_active && exp_idx == job_n) popped_last = 1;
        end
        if (done) done_count++;
      end

      reset_next = rst;
      if (rst) begin
        job_active = 0; job_n = 0; ren_cnt = 0; pop_cnt = 0; exp_idx = 0;
        rd_valid = 0; prev_valid = 0; prev_ready = 0; done_exp = 0;
        for (int k = 0; k < 4; k++) model_act[k] = 0;
      end else begin
        if (popped_last) begin
          done_next = 1; job_active = 0; job_n = 0;
        end else if (!ja_now && start) begin
          if (num_neurons == '0) done_next = 1;
          else begin
            job_active = 1; job_n = int'(num_neurons);
            ren_cnt = 0; pop_cnt = 0; exp_idx = 0;
          end
        end
        if (!ja_now && act_we) model_act[act_idx] = int'(act_wdata);
        rd_valid   = wmem_ren;
        rd_addr    = int'(wmem_addr);
        prev_valid = res_valid;
        prev_ready = res_ready;
        prev_idx   = res_idx;
        prev_data  = res_data;
        done_exp   = done_next;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_act(input int idx, input int val);
    act_we = 1'b1; act_idx = 2'(idx); act_wdata = 5'(val);
    step();
    act_we = 1'b0;
  endtask

  task automatic launch(input int n);
    start = 1'b1; num_neurons = AW'(n);
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check(name, seen, 1);
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int dc0;
    bit seen;
    rst = 1'b1; start = 1'b0; num_neurons = '0; act_we = 1'b0;
    act_idx = '0; act_wdata = '0; res_ready = 1'b1;
    @(posedge clk); #1 mon_en = 1;
    step();
    rst = 1'b0;
    step();

    // Basic job: acts {1,2,3,4}, w={i,1,0,0} -> result i+2.
    write_act(0, 1); write_act(1, 2); write_act(2, 3); write_act(3, 4);
    dc0 = done_count;
    launch(4);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("A_ren_c1", wmem_ren, 1);
        check("A_addr_c1", wmem_addr, 0);
        check("A_busy_c1", busy, 1);
      end
      if (c == 5) check("A_ren_c5", wmem_ren, 0);
      if (c >= 5 && c <= 8) begin
        check("A_valid", res_valid, 1);
        check("A_idx", res_idx, c - 5);
        check("A_data", res_data, c - 3);
      end
      if (c == 9) begin
        check("A_done_c9", done, 1);
        check("A_busy_c9", busy, 0);
        check("A_valid_c9", res_valid, 0);
      end
      if (c == 10) check("A_done_c10", done, 0);
    end
    step();
    check("A_done_once", done_count, dc0 + 1);

    // Zero job.
    launch(0);
    @(negedge clk);
    check("Z_done", done, 1);
    check("Z_busy", busy, 0);
    check("Z_ren", wmem_ren, 0);
    @(negedge clk);
    check("Z_done_off", done, 0);
    step();

    // IDLE act write takes effect; act_we and start while busy are ignored.
    write_act(0, 3);
    dc0 = done_count;
    launch(12);
    repeat (3) step();
    act_we = 1'b1; act_idx = 2'd0; act_wdata = 5'd31;
    start = 1'b1; num_neurons = AW'(5);
    step();
    act_we = 1'b0; start = 1'b0;
    wait_done("C_wait", 200);
    check("C_data1", got_data[1], 5);
    check("C_data9", got_data[9], 29);
    check("C_sat10", got_data[10], 31);
    repeat (10) step();
    check("C_done_once", done_count, dc0 + 1);
    check("C_idle", busy, 0);

    // Backpressure: only DEPTH reads while the consumer stalls.
    dc0 = done_count;
    res_ready = 1'b0;
    launch(20);
    repeat (40) step();
    check("D_reads", ren_cnt, DEPTH);
    check("D_valid", res_valid, 1);
    check("D_head", res_idx, 0);
    res_ready = 1'b1;
    wait_done("D_wait", 200);
    check("D_count", exp_idx, 20);
    check("D_done_once", done_count, dc0 + 1);

    // Reset mid-run: abort with no done pulse.
    dc0 = done_count;
    launch(10);
    repeat (3) step();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (20) step();
    check("E_no_done", done_count, dc0);
    check("E_busy", busy, 0);
    check("E_ren", wmem_ren, 0);

    // Random consumer, full-size job.
    write_act(0, 1); write_act(1, 1);
    dc0 = done_count;
    launch(63);
    seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      @(posedge clk); #1;
      res_ready = 1'($urandom_range(0, 1));
    end
    check("F_wait", seen, 1);
    res_ready = 1'b1;
    step();
    check("F_count", exp_idx, 63);
    check("F_done_once", done_count, dc0 + 1);
    check("F_sat31", got_data[31], 31);
    check("F_data62", got_data[62], 31);
    check("F_data40", got_data[40], 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
